// File: rtl/ar_pkg.sv
// Shared definitions for the ARIMA datapath stages (AR and MA).
//   ar_state_e : sequencer states of the AR engine
//   acc_width  : accumulator width for N-bit operands over up to p_max taps
//   AR_*       : default sample width, Q-format fraction bits and order
package ar_pkg;

  typedef enum logic [1:0] {IDLE, MAC, OUT} ar_state_e;

  localparam int AR_N     = 32;
  localparam int AR_Q     = 15;
  localparam int AR_P_MAX = 16;

  // Full-precision products plus headroom for summing p_max of them.
  function automatic int acc_width(input int n, input int p_max);
    return 2 * n + $clog2(p_max);
  endfunction

endpackage

// File: rtl/ar_seq_filter_if.sv
// Streaming bus of the AR filter: sample input with run-time order, and
// filtered output, both valid/ready.
//   master : upstream/downstream side (drives samples, accepts outputs)
//   slave  : filter side
interface ar_seq_filter_if #(
  parameter int N     = 32,
  parameter int P_MAX = 16
);
  logic                    in_valid;
  logic                    in_ready;
  logic [N-1:0]            in_data;
  logic [$clog2(P_MAX):0]  p_order;
  logic                    out_valid;
  logic                    out_ready;
  logic [N-1:0]            out_data;

  modport master (
    output in_valid, in_data, p_order, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, p_order, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/q_round_sat.sv
// Combinational Q-format narrowing: rounds an ACC_W accumulator by Q bits
// (half toward +inf) and clamps to the signed N-bit range.
//   acc_i  : signed accumulator
//   data_o : rounded, saturated result
//   sat_o  : high when clamping occurred
module q_round_sat
  import ar_pkg::*;
#(
  parameter int ACC_W = acc_width(AR_N, AR_P_MAX),
  parameter int N     = AR_N,
  parameter int Q     = AR_Q
) (
  input  logic signed [ACC_W-1:0] acc_i,
  output logic        [N-1:0]     data_o,
  output logic                    sat_o
);

  // One extra bit so adding the half-LSB can never wrap.
  localparam logic signed [ACC_W:0] HALF = {{(ACC_W-Q+1){1'b0}}, 1'b1, {(Q-1){1'b0}}};
  localparam logic signed [ACC_W:0] MAXV = {{(ACC_W-N+2){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [ACC_W:0] MINV = {{(ACC_W-N+2){1'b1}}, {(N-1){1'b0}}};

  logic signed [ACC_W:0] biased;
  logic signed [ACC_W:0] shifted;

  assign biased  = $signed({acc_i[ACC_W-1], acc_i}) + HALF;
  assign shifted = biased >>> Q;

  always_comb begin
    data_o = shifted[N-1:0];
    sat_o  = 1'b0;
    if (shifted > MAXV) begin
      data_o = {1'b0, {(N-1){1'b1}}};
      sat_o  = 1'b1;
    end else if (shifted < MINV) begin
      data_o = {1'b1, {(N-1){1'b0}}};
      sat_o  = 1'b1;
    end
  end

endmodule

// File: rtl/ar_seq_filter.sv
// Sequential AR filter: y[t] = sum_{k<p} coef[k]*x[t-k] with one shared MAC.
//   clk, rst   : clock, synchronous active-high reset
//   bus        : sample in / result out stream (slave side)
//   coef_we/addr/wdata : coefficient write port, honoured in IDLE only
//   clear      : flush history and overflow, honoured in IDLE only
//   overflow   : sticky saturation flag
module ar_seq_filter
  import ar_pkg::*;
#(
  parameter int N     = AR_N,
  parameter int Q     = AR_Q,
  parameter int P_MAX = AR_P_MAX
) (
  input  logic                     clk,
  input  logic                     rst,
  ar_seq_filter_if.slave           bus,
  input  logic                     coef_we,
  input  logic [$clog2(P_MAX)-1:0] coef_addr,
  input  logic [N-1:0]             coef_wdata,
  input  logic                     clear,
  output logic                     overflow
);

  localparam int AW    = $clog2(P_MAX);
  localparam int PW    = AW + 1;
  localparam int ACC_W = acc_width(N, P_MAX);

  ar_state_e                state_q;
  logic signed [N-1:0]      hist_q [P_MAX];
  logic signed [N-1:0]      coef_q [P_MAX];
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [PW-1:0]            k_q, p_q, p_d;
  logic [N-1:0]             out_data_q;
  logic                     ovf_q;

  logic [AW-1:0]            kidx;
  logic signed [2*N-1:0]    prod;
  logic [N-1:0]             rs_data;
  logic                     rs_sat;

  assign bus.in_ready  = (state_q == IDLE) && !clear && !rst;
  assign bus.out_valid = (state_q == OUT);
  assign bus.out_data  = out_data_q;
  assign overflow      = ovf_q;

  // Order is clamped once, at acceptance; later p_order changes are ignored.
  assign p_d  = (bus.p_order > PW'(P_MAX)) ? PW'(P_MAX) : bus.p_order;

  assign kidx  = k_q[AW-1:0];
  assign prod  = hist_q[kidx] * coef_q[kidx];
  assign acc_d = acc_q + {{(ACC_W-2*N){prod[2*N-1]}}, prod};

  // Rounds the value the accumulator is about to take, so the last tap
  // loads out_data in the same cycle it is accumulated.
  q_round_sat #(.ACC_W(ACC_W), .N(N), .Q(Q)) u_rs (
    .acc_i  (acc_d),
    .data_o (rs_data),
    .sat_o  (rs_sat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      k_q        <= '0;
      p_q        <= '0;
      out_data_q <= '0;
      ovf_q      <= 1'b0;
      for (int i = 0; i < P_MAX; i++) begin
        hist_q[i] <= '0;
        coef_q[i] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (coef_we) coef_q[coef_addr] <= coef_wdata;
          if (clear) begin
            for (int i = 0; i < P_MAX; i++) hist_q[i] <= '0;
            ovf_q <= 1'b0;
          end else if (bus.in_valid) begin
            for (int i = P_MAX-1; i > 0; i--) hist_q[i] <= hist_q[i-1];
            hist_q[0] <= bus.in_data;
            p_q       <= p_d;
            acc_q     <= '0;
            k_q       <= '0;
            if (p_d == '0) begin
              out_data_q <= '0;
              state_q    <= OUT;
            end else begin
              state_q <= MAC;
            end
          end
        end
        MAC: begin
          acc_q <= acc_d;
          k_q   <= k_q + PW'(1);
          if (k_q == p_q - PW'(1)) begin
            out_data_q <= rs_data;
            if (rs_sat) ovf_q <= 1'b1;
            state_q <= OUT;
          end
        end
        OUT: begin
          if (bus.out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ar_seq_filter.sv
module tb_ar_seq_filter;
  localparam int N     = 32;
  localparam int Q     = 15;
  localparam int P_MAX = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        coef_we = 1'b0;
  logic [3:0]  coef_addr = '0;
  logic [31:0] coef_wdata = '0;
  logic        clear = 1'b0;
  logic        overflow;

  ar_seq_filter_if #(.N(N), .P_MAX(P_MAX)) bus ();

  ar_seq_filter #(.N(N), .Q(Q), .P_MAX(P_MAX)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_wdata (coef_wdata),
    .clear      (clear),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  // ---------------- reference model ----------------
  typedef struct {int data; bit ovf;} exp_t;
  exp_t sb[$];
  int   m_hist[P_MAX];
  int   m_coef[P_MAX];
  bit   m_ovf;

  function automatic exp_t model_y(input int p);
    logic signed [127:0] acc, r;
    exp_t e;
    acc = '0;
    for (int k = 0; k < p; k++) acc = acc + m_hist[k] * m_coef[k];
    r = (acc + (128'sd1 <<< (Q-1))) >>> Q;
    if (r > 128'sd2147483647) begin
      e.data = 32'h7fffffff; m_ovf = 1'b1;
    end else if (r < -128'sd2147483648) begin
      e.data = $signed(32'h80000000); m_ovf = 1'b1;
    end else begin
      e.data = $signed(r[31:0]);
    end
    e.ovf = m_ovf;
    return e;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  exp_t mon_e;
  bit   prev_stall = 1'b0;
  int   prev_data;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && bus.out_valid)
        check("hold_out_data", $signed(bus.out_data), prev_data);
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) fail_now("unexpected_output");
        else begin
          mon_e = sb.pop_front();
          check("out_data", $signed(bus.out_data), mon_e.data);
          check("overflow_at_out", overflow, mon_e.ovf);
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = $signed(bus.out_data);
    end
  end

  bit rnd_bp = 1'b0;
  initial forever begin
    @(posedge clk); #1;
    if (rnd_bp) bus.out_ready = ($urandom_range(0, 3) != 0);
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input int x, input int p, input bit wr, input int wa, input int wd);
    int g;
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.in_data = x; bus.p_order = 5'(p);
    coef_we = wr; coef_addr = 4'(wa); coef_wdata = wd;
    g = 0;
    do begin @(negedge clk); g++; end while (!bus.in_ready && g < 200);
    if (!bus.in_ready) fail_now("accept_timeout");
    else begin
      if (wr) m_coef[wa] = wd;
      for (int i = P_MAX-1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = x;
      sb.push_back(model_y(p > P_MAX ? P_MAX : p));
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0; coef_we = 1'b0;
    bus.p_order = 5'($urandom_range(0, 31)); bus.in_data = $urandom;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (lat < 100) begin
      @(negedge clk); lat++;
      if (bus.out_valid) break;
    end
  endtask

  task automatic drain();
    int g = 0;
    while (sb.size() != 0 && g < 3000) begin @(negedge clk); g++; end
    if (sb.size() != 0) fail_now("drain_timeout");
  endtask

  task automatic write_coef(input int a, input int d);
    @(posedge clk); #1;
    coef_we = 1'b1; coef_addr = 4'(a); coef_wdata = d;
    @(posedge clk); #1;
    coef_we = 1'b0;
    m_coef[a] = d;
  endtask

  task automatic do_clear(input bit with_valid);
    @(posedge clk); #1;
    clear = 1'b1; bus.in_valid = with_valid; bus.in_data = 12345; bus.p_order = 5'd1;
    @(negedge clk);
    check("clear_blocks_in_ready", bus.in_ready, 0);
    @(posedge clk); #1;
    clear = 1'b0; bus.in_valid = 1'b0;
    for (int i = 0; i < P_MAX; i++) m_hist[i] = 0;
    m_ovf = 1'b0;
  endtask

  function automatic int rnd_val();
    int v = $urandom;
    if ($urandom_range(0, 4) == 0) return v;
    return v >>> $urandom_range(10, 20);
  endfunction

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- main sequence ----------------
  initial begin
    int lat, d, seen;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.p_order = '0; bus.out_ready = 1'b1;
    for (int i = 0; i < P_MAX; i++) begin m_hist[i] = 0; m_coef[i] = 0; end
    m_ovf = 1'b0;

    @(posedge clk); @(posedge clk);
    @(negedge clk);
    check("rst_in_ready_low", bus.in_ready, 0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", bus.in_ready, 1);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_out_data", bus.out_data, 0);
    check("reset_overflow", overflow, 0);

    // zero coefficients after reset
    send(rnd_val(), 4, 0, 0, 0); wait_out(lat); check("lat_p4", lat, 5); drain();

    // single tap and rounding
    write_coef(0, 16384);
    send(32768, 1, 0, 0, 0); wait_out(lat); check("lat_p1", lat, 2); drain();
    write_coef(0, 1);
    send(16384, 1, 0, 0, 0); drain();
    send(-16384, 1, 0, 0, 0); drain();

    // order 3 from a clean history
    do_clear(1'b0);
    write_coef(0, 32768); write_coef(1, 16384); write_coef(2, 8192);
    send(32768, 3, 0, 0, 0); send(65536, 3, 0, 0, 0); send(98304, 3, 0, 0, 0); drain();

    // saturation and sticky overflow
    do_clear(1'b0);
    write_coef(0, 65536);
    send(32'h7fffffff, 1, 0, 0, 0); drain();
    write_coef(0, 16384);
    send(100, 1, 0, 0, 0); send(-200, 2, 0, 0, 0); drain();
    do_clear(1'b0);
    @(negedge clk); check("overflow_after_clear", overflow, 0);

    // backpressure
    bus.out_ready = 1'b0;
    send(1000, 2, 0, 0, 0); wait_out(lat); check("lat_p2", lat, 3);
    d = $signed(bus.out_data);
    repeat (5) begin
      @(negedge clk);
      check("bp_out_valid", bus.out_valid, 1);
      check("bp_out_data", $signed(bus.out_data), d);
      check("bp_in_ready", bus.in_ready, 0);
    end
    @(posedge clk); #1; bus.out_ready = 1'b1;
    drain();

    // order bounds
    send(777, 0, 0, 0, 0); wait_out(lat); check("lat_p0", lat, 1); drain();
    send(5, 20, 0, 0, 0); wait_out(lat); check("lat_p20", lat, 17); drain();

    // coefficient write during MAC is dropped
    write_coef(1, 16384);
    send(4096, 4, 0, 0, 0);
    @(posedge clk); #1; coef_we = 1'b1; coef_addr = 4'd1; coef_wdata = 32'h40000000;
    @(posedge clk); #1; coef_we = 1'b0;
    drain();
    send(2048, 4, 0, 0, 0); drain();

    // write in the handshake cycle is seen by that sample
    send(32768, 2, 1'b1, 0, 8192); drain();

    // clear beats in_valid and zeros history
    do_clear(1'b1);
    send(32768, 3, 0, 0, 0); drain();

    // reset mid-MAC aborts the sample
    send(1234, 16, 0, 0, 0);
    @(posedge clk); #1; @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    void'(sb.pop_back());
    for (int i = 0; i < P_MAX; i++) begin m_hist[i] = 0; m_coef[i] = 0; end
    m_ovf = 1'b0;
    @(negedge clk); check("in_ready_after_rst", bus.in_ready, 1);
    seen = 0;
    repeat (20) begin @(negedge clk); if (bus.out_valid) seen = 1; end
    check("abort_no_output", seen, 0);
    send(rnd_val(), 4, 0, 0, 0); drain();

    // randomized traffic with random backpressure
    rnd_bp = 1'b1;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 2) == 0)
        send(rnd_val(), $urandom_range(0, 20), 1'b1, $urandom_range(0, P_MAX-1), rnd_val());
      else
        send(rnd_val(), $urandom_range(0, 20), 1'b0, 0, 0);
    end
    drain();
    rnd_bp = 1'b0;
    @(posedge clk); #1; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
